// File: rtl/hx_row_packer_pkg.sv
// rtl/hx_row_packer_pkg.sv - shared F_case row types, widths and slot offset helpers
package hx_row_packer_pkg;

   localparam int DOUBLE_W = 64;

   typedef logic [DOUBLE_W-1:0] double_t;

   localparam double_t ZERO_DOUBLE = '0;

   // Symbol width wide enough to carry (and detect) values up to 2*A-1
   function automatic int hx_awidth(input int a);
      return $clog2(a) + 1;
   endfunction

   // Bit offset of slot k inside a packed H row
   function automatic int h_off(input int k);
      return k * DOUBLE_W;
   endfunction

   // Bit offset of slot k inside a packed x row
   function automatic int x_off(input int k, input int aw);
      return k * aw;
   endfunction

endpackage

// File: rtl/hx_row_packer_if.sv
// rtl/hx_row_packer_if.sv - pair stream in, packed row out, with row handshake
interface hx_row_packer_if
   import hx_row_packer_pkg::*;
#(
   parameter int J      = 14,
   parameter int AWIDTH = 2
);
   logic [DOUBLE_W-1:0]   s_h_tdata;
   logic [AWIDTH-1:0]     s_x_tdata;
   logic                  s_tvalid;
   logic                  s_tlast;
   logic                  s_tready;
   logic                  row_ready;
   logic [J*DOUBLE_W-1:0] H;
   logic                  H_tvalid;
   logic [J*AWIDTH-1:0]   x;
   logic                  x_tvalid;

   modport master (
      output s_h_tdata, s_x_tdata, s_tvalid, s_tlast, row_ready,
      input  s_tready, H, H_tvalid, x, x_tvalid
   );

   modport slave (
      input  s_h_tdata, s_x_tdata, s_tvalid, s_tlast, row_ready,
      output s_tready, H, H_tvalid, x, x_tvalid
   );
endinterface

// File: rtl/hx_row_packer_buf.sv
// rtl/hx_row_packer_buf.sv - J-slot row register bank with slot write, zero pad and bulk load
module hx_row_buf
   import hx_row_packer_pkg::*;
#(
   parameter int J         = 14,
   parameter int AWIDTH    = 2,
   parameter int CW        = 4,
   parameter bit NEXT_VIEW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [CW-1:0]         wr_slot,
   input  logic [DOUBLE_W-1:0]   wr_h,
   input  logic [AWIDTH-1:0]     wr_x,
   input  logic                  pad_en,
   input  logic [CW-1:0]         pad_from,
   input  logic                  load_en,
   input  logic [J*DOUBLE_W-1:0] load_h,
   input  logic [J*AWIDTH-1:0]   load_x,
   output logic [J*DOUBLE_W-1:0] row_h,
   output logic [J*AWIDTH-1:0]   row_x
);
   logic [J*DOUBLE_W-1:0] h_q, h_d;
   logic [J*AWIDTH-1:0]   x_q, x_d;

   // Next row contents: bulk load wins, else write one slot and optionally zero the tail
   always_comb begin
      h_d = h_q;
      x_d = x_q;
      if (load_en) begin
         h_d = load_h;
         x_d = load_x;
      end else begin
         for (int k = 0; k < J; k++) begin
            if (wr_en && (wr_slot == CW'(k))) begin
               h_d[h_off(k) +: DOUBLE_W]       = wr_h;
               x_d[x_off(k, AWIDTH) +: AWIDTH] = wr_x;
            end else if (pad_en && (CW'(k) >= pad_from)) begin
               h_d[h_off(k) +: DOUBLE_W]       = ZERO_DOUBLE;
               x_d[x_off(k, AWIDTH) +: AWIDTH] = '0;
            end
         end
      end
   end

   // Row storage, cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         x_q <= '0;
      end else begin
         h_q <= h_d;
         x_q <= x_d;
      end
   end

   // The fill bank exposes its next state so a closing pair can move to pending on the same edge
   assign row_h = NEXT_VIEW ? h_d : h_q;
   assign row_x = NEXT_VIEW ? x_d : x_q;

endmodule

// File: rtl/hx_row_packer.sv
// rtl/hx_row_packer.sv - packs serial (H, x) pairs into double-buffered J-wide rows
module hx_row_packer
   import hx_row_packer_pkg::*;
#(
   parameter int J = 14,
   parameter int I = 7,
   parameter int A = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   hx_row_packer_if.slave bus,
   output logic [15:0]    rows_out,
   output logic           short_row_err,
   output logic           sym_err
);
   localparam int AWIDTH = hx_awidth(A);
   localparam int CW     = (J > 1) ? $clog2(J) : 1;
   localparam int HW     = J * DOUBLE_W;
   localparam int XW     = J * AWIDTH;
   localparam logic [AWIDTH-1:0] X_LIMIT   = AWIDTH'(A);
   localparam logic [AWIDTH-1:0] X_MAX     = AWIDTH'(A - 1);
   localparam logic [CW-1:0]     LAST_SLOT = CW'(J - 1);

   logic [CW-1:0]     fill_cnt;
   logic              fill_full;
   logic              pend_valid;
   logic              row_tvalid;
   logic              accept, close, partial, emit, move, sym_bad;
   logic [AWIDTH-1:0] x_in;
   logic [HW-1:0]     fill_h, pend_h, out_h;
   logic [XW-1:0]     fill_x, pend_x, out_x;

   // Handshake decode: accept, row close, emission and fill-to-pending transfer
   always_comb begin
      accept  = bus.s_tvalid & ~fill_full;
      close   = accept & (bus.s_tlast | (fill_cnt == LAST_SLOT));
      partial = accept & bus.s_tlast & (fill_cnt != LAST_SLOT);
      emit    = pend_valid & bus.row_ready;
      move    = (close | fill_full) & (~pend_valid | emit);
      sym_bad = bus.s_x_tdata >= X_LIMIT;
      x_in    = sym_bad ? X_MAX : bus.s_x_tdata;
   end

   hx_row_buf #(.J(J), .AWIDTH(AWIDTH), .CW(CW), .NEXT_VIEW(1'b1)) u_fill (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (accept),
      .wr_slot  (fill_cnt),
      .wr_h     (bus.s_h_tdata),
      .wr_x     (x_in),
      .pad_en   (partial),
      .pad_from (fill_cnt + 1'b1),
      .load_en  (1'b0),
      .load_h   ('0),
      .load_x   ('0),
      .row_h    (fill_h),
      .row_x    (fill_x)
   );

   hx_row_buf #(.J(J), .AWIDTH(AWIDTH), .CW(CW), .NEXT_VIEW(1'b0)) u_pend (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (1'b0),
      .wr_slot  ('0),
      .wr_h     ('0),
      .wr_x     ('0),
      .pad_en   (1'b0),
      .pad_from ('0),
      .load_en  (move),
      .load_h   (fill_h),
      .load_x   (fill_x),
      .row_h    (pend_h),
      .row_x    (pend_x)
   );

   // Fill counter, buffer occupancy, output row registers and status counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt      <= '0;
         fill_full     <= 1'b0;
         pend_valid    <= 1'b0;
         row_tvalid    <= 1'b0;
         out_h         <= '0;
         out_x         <= '0;
         rows_out      <= '0;
         short_row_err <= 1'b0;
         sym_err       <= 1'b0;
      end else begin
         if (close) begin
            fill_cnt <= '0;
         end else if (accept) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
         fill_full  <= (close | fill_full) & ~move;
         pend_valid <= move | (pend_valid & ~emit);
         row_tvalid <= emit;
         if (emit) begin
            out_h    <= pend_h;
            out_x    <= pend_x;
            rows_out <= rows_out + 16'd1;
         end
         if (partial) begin
            short_row_err <= 1'b1;
         end
         if (accept && sym_bad) begin
            sym_err <= 1'b1;
         end
      end
   end

   assign bus.s_tready = ~fill_full;
   assign bus.H        = out_h;
   assign bus.x        = out_x;
   assign bus.H_tvalid = row_tvalid;
   assign bus.x_tvalid = row_tvalid;

endmodule

// File: tb/tb_hx_row_packer.sv
// tb/tb_hx_row_packer.sv - directed table-driven bench for hx_row_packer
module tb_hx_row_packer;

   localparam int J  = 14;
   localparam int I  = 7;
   localparam int A  = 2;
   localparam int AW = 2;

   typedef struct {
      int base;
      int len;
      bit last;
      int bad;
      int exp_rows;
      bit exp_short;
      bit exp_sym;
   } row_vec_t;

   typedef struct {
      logic [J*64-1:0] h;
      logic [J*AW-1:0] x;
      int              cyc;
   } pulse_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] rows_out;
   logic        short_row_err;
   logic        sym_err;

   int       checks = 0;
   int       errors = 0;
   int       cyc = 0;
   int       acc_cnt = 0;
   int       ready_low = 0;
   bit       track_ready = 0;
   bit       stream_done = 0;
   pulse_t   pulses[$];
   row_vec_t vecs[7];

   hx_row_packer_if #(.J(J), .AWIDTH(AW)) bus ();

   hx_row_packer #(.J(J), .I(I), .A(A)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .rows_out      (rows_out),
      .short_row_err (short_row_err),
      .sym_err       (sym_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.H_tvalid || bus.x_tvalid) begin
         pulse_t p;
         checks++;
         if (bus.H_tvalid !== bus.x_tvalid) begin
            errors++;
            $display("FAIL tvalid_align H_tvalid=%0b x_tvalid=%0b", bus.H_tvalid, bus.x_tvalid);
         end
         p.h   = bus.H;
         p.x   = bus.x;
         p.cyc = cyc;
         pulses.push_back(p);
      end
      if (track_ready && (bus.s_tready !== 1'b1)) ready_low++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [J*64-1:0] exp_h(input int base, input int len);
      logic [J*64-1:0] r;
      r = '0;
      for (int k = 0; k < len; k++) r[k*64 +: 64] = $realtobits(real'(base + k + 1));
      return r;
   endfunction

   function automatic logic [J*AW-1:0] exp_x(input int len, input int bad);
      logic [J*AW-1:0] r;
      r = '0;
      for (int k = 0; k < len; k++) r[k*AW +: AW] = (k == bad) ? AW'(A - 1) : AW'(k % 2);
      return r;
   endfunction

   task automatic check_row(input string name, input logic [J*64-1:0] h, input logic [J*AW-1:0] x,
                            input int base, input int len, input int bad);
      logic [J*64-1:0] eh;
      logic [J*AW-1:0] ex;
      eh = exp_h(base, len);
      ex = exp_x(len, bad);
      checks++;
      if (h !== eh) begin
         errors++;
         for (int k = 0; k < J; k++) begin
            if (h[k*64 +: 64] !== eh[k*64 +: 64]) begin
               $display("FAIL %s_h slot %0d actual=%h required=%h", name, k, h[k*64 +: 64], eh[k*64 +: 64]);
               break;
            end
         end
      end
      checks++;
      if (x !== ex) begin
         errors++;
         $display("FAIL %s_x actual=%h required=%h", name, x, ex);
      end
   endtask

   task automatic send_pair(input logic [63:0] h, input logic [AW-1:0] xs, input logic last,
                            output int acc_edge);
      logic rdy;
      int   budget;
      budget = 0;
      bus.s_h_tdata = h;
      bus.s_x_tdata = xs;
      bus.s_tlast   = last;
      bus.s_tvalid  = 1'b1;
      forever begin
         rdy = bus.s_tready;
         @(posedge clk);
         #1;
         if (rdy === 1'b1) begin
            acc_cnt++;
            break;
         end
         budget++;
         if (budget > 300) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=blocked required=accepted");
            break;
         end
      end
      acc_edge = cyc;
   endtask

   task automatic send_row(input int base, input int len, input bit last, input int bad,
                           output int close_e);
      for (int k = 0; k < len; k++) begin
         send_pair($realtobits(real'(base + k + 1)), (k == bad) ? AW'(3) : AW'(k % 2),
                   last && (k == len - 1), close_e);
      end
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int b;
      b = 0;
      while ((pulses.size() < n) && (b < budget)) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk("pulse_count", 64'(pulses.size()), 64'(n));
   endtask

   task automatic run_row(input row_vec_t v);
      int close_e;
      pulses.delete();
      send_row(v.base, v.len, v.last, v.bad, close_e);
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      wait_pulses(1, 30);
      if (pulses.size() >= 1) begin
         chk("latency", 64'(pulses[0].cyc - close_e), 64'd1);
         check_row("row", pulses[0].h, pulses[0].x, v.base, v.len, v.bad);
      end
      chk("rows_out", 64'(rows_out), 64'(v.exp_rows));
      chk("short_row_err", 64'(short_row_err), 64'(v.exp_short));
      chk("sym_err", 64'(sym_err), 64'(v.exp_sym));
      @(negedge clk);
      #1;
      chk("tvalid_drop", 64'(bus.H_tvalid), 64'd0);
      check_row("hold", bus.H, bus.x, v.base, v.len, v.bad);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e;
      int b;

      vecs[0] = '{base:   0, len: 14, last: 0, bad: -1, exp_rows: 1, exp_short: 0, exp_sym: 0};
      vecs[1] = '{base: 100, len: 14, last: 1, bad: -1, exp_rows: 2, exp_short: 0, exp_sym: 0};
      vecs[2] = '{base: 200, len:  5, last: 1, bad: -1, exp_rows: 3, exp_short: 1, exp_sym: 0};
      vecs[3] = '{base: 300, len: 14, last: 0, bad: -1, exp_rows: 4, exp_short: 1, exp_sym: 0};
      vecs[4] = '{base: 400, len: 14, last: 0, bad:  3, exp_rows: 5, exp_short: 1, exp_sym: 1};
      vecs[5] = '{base: 500, len:  1, last: 1, bad: -1, exp_rows: 6, exp_short: 1, exp_sym: 1};
      vecs[6] = '{base: 600, len: 14, last: 0, bad: -1, exp_rows: 7, exp_short: 1, exp_sym: 1};

      rst_n         = 1'b0;
      bus.s_h_tdata = '0;
      bus.s_x_tdata = '0;
      bus.s_tvalid  = 1'b0;
      bus.s_tlast   = 1'b0;
      bus.row_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_tvalid", 64'(bus.H_tvalid), 64'd0);
      chk("rst_rows_out", 64'(rows_out), 64'd0);
      chk("rst_short", 64'(short_row_err), 64'd0);
      chk("rst_sym", 64'(sym_err), 64'd0);
      chk("rst_h_any", 64'(|bus.H), 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 64'(bus.s_tready), 64'd1);

      for (int i = 0; i < 7; i++) run_row(vecs[i]);

      pulses.delete();
      ready_low   = 0;
      track_ready = 1'b1;
      send_row(1000, 14, 1'b0, -1, e);
      send_row(1100, 14, 1'b0, -1, e);
      bus.s_tvalid = 1'b0;
      wait_pulses(2, 30);
      track_ready = 1'b0;
      chk("stream_ready_low", 64'(ready_low), 64'd0);
      if (pulses.size() >= 2) begin
         chk("stream_spacing", 64'(pulses[1].cyc - pulses[0].cyc), 64'd14);
         check_row("stream0", pulses[0].h, pulses[0].x, 1000, 14, -1);
         check_row("stream1", pulses[1].h, pulses[1].x, 1100, 14, -1);
      end
      chk("stream_rows_out", 64'(rows_out), 64'd9);

      pulses.delete();
      send_row(700, 7, 1'b0, -1, e);
      bus.s_tvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rows_out", 64'(rows_out), 64'd0);
      chk("arst_short", 64'(short_row_err), 64'd0);
      chk("arst_sym", 64'(sym_err), 64'd0);
      chk("arst_h_any", 64'(|bus.H), 64'd0);
      chk("arst_x_any", 64'(|bus.x), 64'd0);
      chk("arst_tvalid", 64'(bus.H_tvalid), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_no_pulse", 64'(pulses.size()), 64'd0);
      run_row('{base: 800, len: 14, last: 0, bad: -1, exp_rows: 1, exp_short: 0, exp_sym: 0});

      apply_reset();
      pulses.delete();
      acc_cnt       = 0;
      stream_done   = 1'b0;
      bus.row_ready = 1'b0;
      fork
         begin
            int se;
            for (int r = 0; r < 3; r++) send_row(2000 + 100 * r, 14, 1'b0, -1, se);
            bus.s_tvalid = 1'b0;
            stream_done  = 1'b1;
         end
      join_none
      b = 0;
      while ((acc_cnt < 28) && (b < 80)) begin
         @(negedge clk);
         b++;
      end
      repeat (5) @(negedge clk);
      chk("bp_accepted", 64'(acc_cnt), 64'd28);
      chk("bp_ready_low", 64'(bus.s_tready), 64'd0);
      chk("bp_no_pulse", 64'(pulses.size()), 64'd0);
      @(posedge clk);
      #1 bus.row_ready = 1'b1;
      b = 0;
      while (!(stream_done && (pulses.size() >= 3)) && (b < 200)) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk("bp_pulses", 64'(pulses.size()), 64'd3);
      if (pulses.size() >= 3) begin
         chk("bp_back_to_back", 64'(pulses[1].cyc - pulses[0].cyc), 64'd1);
         check_row("bp0", pulses[0].h, pulses[0].x, 2000, 14, -1);
         check_row("bp1", pulses[1].h, pulses[1].x, 2100, 14, -1);
         check_row("bp2", pulses[2].h, pulses[2].x, 2200, 14, -1);
      end
      chk("bp_rows_out", 64'(rows_out), 64'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hx_row_packer.md
Name: hx_row_packer

Overview:
Upstream stage of the F_case row evaluator.
- Accepts a serial stream of (H coefficient, x symbol) pairs, one pair per handshake.
- Packs J consecutive pairs into one row.
- Presents the row as the J-wide H and x buses with aligned one-cycle H_tvalid / x_tvalid pulses.
- Double-buffered (fill row plus pending row), so input streaming continues while a completed row waits for the consumer.

Parameters:
J, 14, elements per row.
I, 7, passed through for consistency with the row evaluator; unused internally.
A, 2, alphabet size; legal x symbol values are 0..A-1.
AWIDTH (localparam), $clog2(A)+1, x symbol width.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
s_h_tdata  in  64  H coefficient (IEEE double, passed through unmodified).
s_x_tdata  in  AWIDTH  x symbol.
s_tvalid  in  1  input pair valid.
s_tlast  in  1  last pair of a frame; forces row close.
s_tready  out  1  input accept; transfer occurs when s_tvalid and s_tready are both high.
row_ready  in  1  downstream may take a row this cycle.
H  out  J*64  packed row; element k at [k*64 +: 64].
H_tvalid  out  1  one-cycle row pulse.
x  out  J*AWIDTH  packed symbols; element k at [k*AWIDTH +: AWIDTH].
x_tvalid  out  1  identical to H_tvalid.
rows_out  out  16  count of rows emitted, wraps at 2^16.
short_row_err  out  1  sticky: a row closed by s_tlast with fewer than J elements.
sym_err  out  1  sticky: an accepted symbol was >= A.

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs 0, fill count 0, fill and pending buffers empty, sticky flags cleared. A partial row in flight is discarded; no pulse is emitted for it.
- Fill: each accepted pair is written to slot fill_cnt, then fill_cnt increments.
- Symbol clamp: a symbol >= A is stored as A-1 and sets sym_err.
- Row closes on the accepted pair with fill_cnt==J-1, or on an accepted pair with s_tlast=1.
  - s_tlast on the J-th element is a normal row (no error).
  - Partial close: slots fill_cnt+1..J-1 are zero-padded (H=64'h0, x=0) and short_row_err is set.
- Transfer: on the close edge, if pending is empty, or pending is being emitted on that same edge, the row moves to pending and fill_cnt returns to 0.
  - Otherwise fill holds the completed row (fill_full=1) and s_tready drops.
  - On the edge where pending empties, fill_full moves to pending.
- s_tready = !fill_full. It is a registered-state function only and never depends on s_tvalid.
- Emission: at an edge with pending valid and row_ready=1, the output registers load pending, H_tvalid=x_tvalid=1 for exactly one cycle, rows_out increments, and pending clears.
  - If row_ready=0, pending is held indefinitely.
  - H and x hold their last row while tvalid=0.
- Latency: closing pair accepted at edge t → pending valid after t → H_tvalid high in the cycle after edge t+1 (2 edges), given row_ready=1 and an empty pipeline.
- Throughput: one row per J cycles sustained; continuous s_tvalid with row_ready=1 never deasserts s_tready.
- Back-to-back emission is possible: tvalid may be high on consecutive cycles when rows of length 1 are closed by s_tlast.
- Simultaneous events:
  - Emission and transfer on the same edge: both occur.
  - Close and reset: reset wins.
- rows_out wraps from 16'hFFFF to 0 without a flag.

Decomposition:
- Shared package (F_case types): AWIDTH function, DOUBLE_W=64, a zero-double constant, and the row_t packing helpers (slot index → bit offset) shared with the row evaluator and its FIFOs.
- One natural sub-module: hx_row_buf, a J-slot register bank with write-slot, zero-pad-from-slot, and load-whole-row controls. Instantiated twice (fill, pending).
- Handshake and counters live in the top.

Test Plan:
1. J=14, A=2, 14 pairs H=k+1 (as doubles), x=k%2, row_ready=1 → one H_tvalid pulse 2 edges after the 14th accept; slot k holds k+1, x alternates 0,1; rows_out=1; no errors.
2. 28 pairs continuous, row_ready=1 → two pulses exactly 14 cycles apart; s_tready constantly 1.
3. row_ready=0, 42 pairs streamed → first 28 accepted; s_tready low from the 29th; raise row_ready → pulses for rows 1 and 2 on consecutive emission opportunities, then row 3 accepted and emitted; rows_out=3.
4. 5 pairs with s_tlast on the 5th → pulse with slots 0..4 loaded, slots 5..13 all-zero; short_row_err=1; next row starts at slot 0.
5. Symbol x=3 with A=2 → stored as 1; sym_err=1 and remains set through later clean rows until reset.
6. Assert rst_n low after 7 pairs of a row → outputs, counters, and flags go to 0 asynchronously; after release, 14 fresh pairs produce one correct row with none of the discarded data.
